// File: rtl/addac4_ctrl_if.sv
// Command port of the adder/accumulator sequencer: valid/ready handshake
// carrying {op, val, cnt}.
interface addac4_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_val;
    logic [3:0] cmd_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_val, cmd_cnt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_val, cmd_cnt,
        output cmd_ready
    );
endinterface

// File: rtl/addac4_ctrl.sv
// Command sequencer for the 4-bit adder/accumulator: FIFO-buffered LOAD/ADD/SUB/MUL
// commands, one accumulator step per clock, MUL as repeated addition.
module addac4_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    addac4_ctrl_if.slave cmd,
    output logic [3:0]   acc_a,
    output logic         acc_sel0,
    output logic         acc_sel1,
    input  logic [3:0]   acc_s,
    input  logic         acc_cout,
    output logic         done_o,
    output logic [3:0]   result_o,
    output logic         ovf_o,
    output logic         busy_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_MUL  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_EXEC,
        S_MZERO,
        S_MADD,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [9:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic [9:0]    head;
    op_t           head_op;

    op_t        op_r;
    logic [3:0] val_r, cnt_r, iter, iter_nxt;
    logic       flag, flag_nxt;
    logic [1:0] sel;
    logic [3:0] a_val;
    logic       done;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = fifo_mem[rd_ptr];
    assign head_op = op_t'(head[9:8]);

    // Readiness comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign cmd.cmd_ready = !rst && (state != S_INIT) && !full;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_val, cmd.cmd_cnt};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            flag  <= 1'b0;
            iter  <= '0;
            op_r  <= OP_LOAD;
            val_r <= '0;
            cnt_r <= '0;
        end else begin
            state <= state_nxt;
            flag  <= flag_nxt;
            iter  <= iter_nxt;
            if (pop) begin
                op_r  <= head_op;
                val_r <= head[7:4];
                cnt_r <= head[3:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        sel       = 2'b00;
        a_val     = '0;
        done      = 1'b0;
        flag_nxt  = flag;
        iter_nxt  = iter;
        case (state)
            S_INIT: begin
                sel       = 2'b11;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = (head_op == OP_MUL) ? S_MZERO : S_EXEC;
                end
            end
            S_EXEC: begin
                a_val     = val_r;
                state_nxt = S_DONE;
                case (op_r)
                    OP_LOAD: begin
                        sel      = 2'b11;
                        flag_nxt = 1'b0;
                    end
                    OP_ADD: begin
                        sel      = 2'b10;
                        flag_nxt = acc_cout;
                    end
                    OP_SUB: begin
                        sel      = 2'b01;
                        flag_nxt = ~acc_cout;
                    end
                    default: begin
                        sel      = 2'b00;
                        flag_nxt = 1'b0;
                    end
                endcase
            end
            S_MZERO: begin
                sel       = 2'b11;
                flag_nxt  = 1'b0;
                iter_nxt  = cnt_r;
                state_nxt = (cnt_r != '0) ? S_MADD : S_DONE;
            end
            S_MADD: begin
                sel      = 2'b10;
                a_val    = val_r;
                flag_nxt = flag | acc_cout;
                iter_nxt = iter - 1'b1;
                if (iter == 4'd1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = (head_op == OP_MUL) ? S_MZERO : S_EXEC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of the state register.
    assign acc_sel1 = rst ? 1'b0 : sel[1];
    assign acc_sel0 = rst ? 1'b0 : sel[0];
    assign acc_a    = rst ? '0 : a_val;
    assign done_o   = done && !rst;
    assign result_o = acc_s;
    assign ovf_o    = done_o && flag;
    assign busy_o   = (state != S_IDLE);

endmodule
